// File: rtl/pipe_reg_skid.sv
// Two-entry skid pipeline register: valid/ready handshake with fully registered in_ready.
// Define PIPE_REG_SKID_CNT_EN to add the xfer_cnt pop counter output.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | neither main nor skid holds a word
// ST_ONE   | main holds the head word, skid empty
// ST_FULL  | main holds the head word, skid holds the next
module pipe_reg_skid #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk_n,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_SKID_CNT_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);

  // Bit 0 is main_valid, bit 1 is skid_valid, so out_valid comes straight off a flop.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             in_ready_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             pop;
  logic             main_ld;
  logic             main_from_skid;
  logic             skid_ld;

  assign out_valid = state[0];
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;

  assign accept = clk_en & in_valid & in_ready_q;
  assign pop    = clk_en & state[0] & out_ready;

  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          main_ld   = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          main_ld = 1'b1;
        end else if (accept) begin
          state_nxt = ST_FULL;
          skid_ld   = 1'b1;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_nxt      = ST_ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(negedge clk_n or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
    end else if (flush) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
    end else begin
      state      <= state_nxt;
      in_ready_q <= ~state_nxt[1];
      if (main_ld) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (skid_ld) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef PIPE_REG_SKID_CNT_EN
  always_ff @(negedge clk_n or posedge rst) begin
    if (rst) begin
      xfer_cnt <= 16'h0000;
    end else if (flush) begin
      xfer_cnt <= 16'h0000;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed-vector bench for pipe_reg_skid; covers reset, streaming, back-pressure,
// enable freeze, flush and (with PIPE_REG_SKID_CNT_EN) the pop counter.
module tb_pipe_reg_skid;

  logic        clk_n = 1'b1;
  logic        rst;
  logic        clk_en;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef PIPE_REG_SKID_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  pipe_reg_skid dut (
    .clk_n     (clk_n),
    .rst       (rst),
    .clk_en    (clk_en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_REG_SKID_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  always #5 clk_n = ~clk_n;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle away from it before checking or driving.
  task automatic tick();
    @(negedge clk_n);
    #2;
  endtask

  task automatic check_port(input string tag, input logic v, input logic r, input logic [15:0] d);
    check_val({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    check_val({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, r});
    check_val({tag, ".out_data"},  {16'd0, out_data},  {16'd0, d});
  endtask

  task automatic push(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    clk_en    = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    #1;
    check_port("por", 1'b0, 1'b1, 16'h0000);
`ifdef PIPE_REG_SKID_CNT_EN
    check_val("por.cnt", {16'd0, xfer_cnt}, 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    check_port("idle", 1'b0, 1'b1, 16'h0000);

    // Streaming: each edge accepts a new word and pops the previous one.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 16'(i);
      tick();
      check_port($sformatf("stream%0d", i), 1'b1, 1'b1, 16'(i));
    end
    in_valid = 1'b0;
    tick();
    check_port("stream_drain", 1'b0, 1'b1, 16'h0008);
    tick();
    check_port("stream_idle", 1'b0, 1'b1, 16'h0008);

    // Back-pressure.
    out_ready = 1'b0;
    push(16'hAAAA);
    check_port("bp1", 1'b1, 1'b1, 16'hAAAA);
    push(16'hBBBB);
    check_port("bp2", 1'b1, 1'b0, 16'hAAAA);
    out_ready = 1'b1;
    tick();
    check_port("bp_pop1", 1'b1, 1'b1, 16'hBBBB);
    tick();
    check_port("bp_pop2", 1'b0, 1'b1, 16'hBBBB);

    // Enable freeze while FULL.
    out_ready = 1'b0;
    push(16'h1111);
    push(16'h2222);
    check_port("frz_full", 1'b1, 1'b0, 16'h1111);
    clk_en    = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h3333;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_port($sformatf("frz%0d", i), 1'b1, 1'b0, 16'h1111);
    end
    clk_en   = 1'b1;
    in_valid = 1'b0;
    tick();
    check_port("frz_pop1", 1'b1, 1'b1, 16'h2222);
    tick();
    check_port("frz_pop2", 1'b0, 1'b1, 16'h2222);

    // Flush while FULL with clk_en low and a concurrent offer.
    out_ready = 1'b0;
    push(16'h5555);
    push(16'h6666);
    check_port("fl_full", 1'b1, 1'b0, 16'h5555);
    clk_en   = 1'b0;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h7777;
    tick();
    check_port("flush", 1'b0, 1'b1, 16'h0000);
    flush    = 1'b0;
    clk_en   = 1'b1;
    in_valid = 1'b0;
    tick();
    check_port("fl_after", 1'b0, 1'b1, 16'h0000);

    // Asynchronous reset in the middle of FULL.
    out_ready = 1'b0;
    push(16'h1234);
    push(16'h5678);
    check_port("rst_full", 1'b1, 1'b0, 16'h1234);
    #1;
    rst = 1'b1;
    #1;
    check_port("rst_now", 1'b0, 1'b1, 16'h0000);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 16'h9999;
    tick();
    check_port("rst_hold1", 1'b0, 1'b1, 16'h0000);
    tick();
    check_port("rst_hold2", 1'b0, 1'b1, 16'h0000);
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    check_port("rst_rel", 1'b0, 1'b1, 16'h0000);
    push(16'hC0DE);
    check_port("rst_push", 1'b1, 1'b1, 16'hC0DE);
    tick();
    check_port("rst_pop", 1'b0, 1'b1, 16'hC0DE);

`ifdef PIPE_REG_SKID_CNT_EN
    // Counter: clear via flush, then 65535 pops, then one more to wrap.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("cnt_clr", {16'd0, xfer_cnt}, 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      in_data = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_val("cnt_max", {16'd0, xfer_cnt}, 32'h0000_FFFF);
    check_val("cnt_max_ov", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    push(16'hBEEF);
    check_val("cnt_hold", {16'd0, xfer_cnt}, 32'h0000_FFFF);
    out_ready = 1'b1;
    tick();
    check_val("cnt_wrap", {16'd0, xfer_cnt}, 32'd0);
    tick();
    out_ready = 1'b0;
    push(16'hF00D);
    out_ready = 1'b1;
    tick();
    check_val("cnt_one", {16'd0, xfer_cnt}, 32'd1);
    out_ready = 1'b0;
    push(16'hF00E);
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    check_val("cnt_flush", {16'd0, xfer_cnt}, 32'd0);
    check_port("cnt_flush", 1'b0, 1'b1, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Parametrised successor to the fixed 16-bit enable/reset register family.
- Generalised to WIDTH bits, with a valid/ready handshake and a 2-entry skid buffer so the ready path is fully registered.
- Adds synchronous flush for pipeline squash.
- Sits between multicycle datapath stages (e.g. fetch→decode, ALU→writeback) where back-pressure must not create a combinational ready chain.

Parameters:
- WIDTH, 16, data width in bits (≥1).
- RESET_VAL, {WIDTH{1'b0}}, value loaded into both data registers on rst or flush.

Ports:
- clk_n  input  1  clock; all state updates on negedge clk_n.
- rst  input  1  reset, asynchronous, active-high.
- clk_en  input  1  clock enable; 0 freezes all state except flush.
- flush  input  1  synchronous squash; empties the buffer.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  buffer can accept; registered.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  out_data valid; registered.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  head data; registered.

Behaviour:
- Storage: main register (drives out_data) and skid register, each with a valid bit. State encoding is EMPTY (neither valid), ONE (main valid), FULL (main and skid valid).
- Outputs:
  - out_valid = main_valid.
  - in_ready = ~skid_valid.
  - All outputs are direct register outputs; no combinational path from out_ready to in_ready.
- Transfer definitions, evaluated at negedge clk_n with clk_en=1:
  - Accept = in_valid & in_ready.
  - Pop = out_valid & out_ready.
- EMPTY:
  - accept → ONE, main ← in_data.
  - Otherwise hold.
- ONE:
  - accept & pop → ONE, main ← in_data (full throughput, 1 word/cycle).
  - accept & ~pop → FULL, skid ← in_data, main held.
  - ~accept & pop → EMPTY.
  - Otherwise hold.
- FULL (in_ready=0, so accept is impossible):
  - pop → ONE, main ← skid, skid_valid ← 0.
  - Otherwise hold.
- Latency: 1 edge from accept to out_valid when the buffer was EMPTY. Order is strictly FIFO; no data is dropped or duplicated.
- clk_en=0: no state or data change. in_valid/out_ready are ignored, and no transfer occurs even if both sides are asserted.
- flush=1 at an edge, regardless of clk_en:
  - State → EMPTY; main and skid ← RESET_VAL.
  - A concurrent accept is discarded.
  - Flush has priority over all handshakes.
- rst=1 (asynchronous, any time including mid-transfer): state EMPTY, out_valid=0, in_ready=1, out_data=RESET_VAL, skid=RESET_VAL. Release is synchronised by the parent; the block only needs to hold reset values while rst=1.
- Data registers change only on accept, on FULL→ONE pop, on flush, or on rst. They do not toggle when idle.
- Upstream and downstream must obey valid-stable-until-ready; the block does not check this.

Optional Feature:
- Macro: PIPE_REG_SKID_CNT_EN.
- Defined:
  - Adds output xfer_cnt [15:0], counting pops (out_valid & out_ready & clk_en) at negedge clk_n.
  - Wraps 16'hFFFF→16'h0000.
  - Cleared to 0 by rst (async) and by flush (sync, flush wins over a concurrent pop).
- Not defined: port and counter are absent. Handshake behaviour is identical in both builds.

Test Plan:
1. Reset: assert rst mid-FULL with out_data=16'h1234 → immediately out_valid=0, in_ready=1, out_data=16'h0000; holds until rst deasserts.
2. Streaming: out_ready=1, clk_en=1, in_valid=1 with data 16'h0001..16'h0008 on consecutive edges → out_data shows 0001..0008 one per edge starting one edge after first accept; in_ready stays 1.
3. Back-pressure: out_ready=0, push 16'hAAAA, 16'hBBBB → after 2nd edge in_ready=0, out_data=AAAA. Raise out_ready for 2 edges → AAAA then BBBB popped; in_ready=1 after first pop; buffer EMPTY.
4. Enable freeze: in FULL with clk_en=0, toggle out_ready=1 and in_valid=1 for 5 edges → state, out_data and in_ready unchanged. Restore clk_en → pops resume in order.
5. Flush: FULL with clk_en=0, assert flush one edge with in_valid=1 → EMPTY, out_valid=0, out_data=RESET_VAL; new data not captured.
6. Counter (PIPE_REG_SKID_CNT_EN): preload by 65535 pops, one more pop → xfer_cnt=16'h0000. Flush with concurrent pop → xfer_cnt=0.
